// File: rtl/dm_bus_ctrl_pkg.sv
// Shared codes and state encoding for the MEM-stage data-memory bus controller.
package dm_bus_ctrl_pkg;

  // Load type codes
  localparam logic [2:0] LOAD_LW  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LHU = 3'b010;
  localparam logic [2:0] LOAD_LB  = 3'b011;
  localparam logic [2:0] LOAD_LBU = 3'b100;

  // Store type codes
  localparam logic [2:0] STORE_SW   = 3'b000;
  localparam logic [2:0] STORE_SH   = 3'b001;
  localparam logic [2:0] STORE_SB   = 3'b010;
  localparam logic [2:0] STORE_PC8  = 3'b011;
  localparam logic [2:0] STORE_NONE = 3'b111;

  // Exception codes reported to the pipeline
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Sign- or zero-extend a 16-bit value to 32 bits
  function automatic logic [31:0] ext16(input logic [15:0] v, input logic sgn);
    return {{16{sgn & v[15]}}, v};
  endfunction

  // Sign- or zero-extend an 8-bit value to 32 bits
  function automatic logic [31:0] ext8(input logic [7:0] v, input logic sgn);
    return {{24{sgn & v[7]}}, v};
  endfunction

endpackage

// File: rtl/dm_bus_ctrl_load_ext.sv
// Selects the addressed byte/halfword of a read word and extends it for WB.
module dm_bus_ctrl_load_ext
  import dm_bus_ctrl_pkg::*;
(
  input  logic [2:0]  load_type,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [15:0] half_v;
  logic [7:0]  byte_v;

  // Lane selection followed by extension according to the load type
  always_comb begin
    half_v = offset[1] ? word[31:16] : word[15:0];
    case (offset)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = 8'h00;
    endcase
    case (load_type)
      LOAD_LW:  result = word;
      LOAD_LH:  result = ext16(half_v, 1'b1);
      LOAD_LHU: result = ext16(half_v, 1'b0);
      LOAD_LB:  result = ext8(byte_v, 1'b1);
      LOAD_LBU: result = ext8(byte_v, 1'b0);
      default:  result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dm_bus_ctrl.sv
// MEM-stage data-memory controller: runs loads/stores as req/ack bus
// transactions, stalls the pipeline while busy, extends load data and
// reports misalignment (AdEL/AdES) and bus timeout (DBE).
module dm_bus_ctrl
  import dm_bus_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_load,
  input  logic [2:0]  load_type,
  input  logic [2:0]  store_type,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic [4:0]  exc_code,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [TO_W-1:0] COUNT_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  logic [TO_W-1:0] count;
  logic [2:0]      lt_q;
  logic [1:0]      off_q;
  logic            load_q;
  logic [4:0]      exc_q;

  logic            adel;
  logic            ades;
  logic            start;
  logic [31:0]     ext_word;

  // Alignment check of the access presented in IDLE (loads only when mem_load)
  always_comb begin
    adel = 1'b0;
    ades = 1'b0;
    if (!reset && state == IDLE && mem_valid) begin
      if (mem_load) begin
        case (load_type)
          LOAD_LW:           adel = (addr[1:0] != 2'b00);
          LOAD_LH, LOAD_LHU: adel = addr[0];
          default:           adel = 1'b0;
        endcase
      end else begin
        case (store_type)
          STORE_SW: ades = (addr[1:0] != 2'b00);
          STORE_SH: ades = addr[0];
          default:  ades = 1'b0;
        endcase
      end
    end else begin
      adel = 1'b0;
      ades = 1'b0;
    end
  end

  // Reset is folded in so stall drops the instant reset asserts
  assign start = !reset && (state == IDLE) && mem_valid && !adel && !ades &&
                 (mem_load || (byteen != 4'b0000));

  assign stall = start || (state == REQ);

  // Misalignment is reported in the cycle it is seen; otherwise the latched code
  assign exc_code = (state == IDLE) ? (adel ? EXC_ADEL : (ades ? EXC_ADES : EXC_NONE))
                                    : exc_q;

  dm_bus_ctrl_load_ext u_load_ext (
    .load_type (lt_q),
    .offset    (off_q),
    .word      (bus_rdata),
    .result    (ext_word)
  );

  // Transaction FSM with registered bus and result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      lt_q        <= 3'b000;
      off_q       <= 2'b00;
      load_q      <= 1'b0;
      exc_q       <= EXC_NONE;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= 32'h0000_0000;
      bus_byteen  <= 4'b0000;
      bus_wdata   <= 32'h0000_0000;
      rdata       <= 32'h0000_0000;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= REQ;
            bus_req    <= 1'b1;
            bus_we     <= !mem_load;
            bus_addr   <= {addr[31:2], 2'b00};
            bus_byteen <= mem_load ? 4'b0000 : byteen;
            bus_wdata  <= wdata;
            lt_q       <= load_type;
            off_q      <= addr[1:0];
            load_q     <= mem_load;
            count      <= '0;
            exc_q      <= EXC_NONE;
          end else begin
            state <= IDLE;
          end
        end
        REQ: begin
          // An ack arriving together with the last allowed cycle still wins
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= DONE;
            if (load_q) begin
              rdata       <= ext_word;
              rdata_valid <= 1'b1;
            end else begin
              rdata_valid <= 1'b0;
            end
          end else if (count == COUNT_LAST) begin
            bus_req     <= 1'b0;
            exc_q       <= EXC_DBE;
            rdata_valid <= load_q;
            state       <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_bus_ctrl.sv
// Self-checking bench for dm_bus_ctrl: transaction-level reference model,
// per-cycle compare process, directed literal checks and random traffic.
module tb_dm_bus_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_load;
  logic [2:0]  load_type, store_type;
  logic [31:0] addr, wdata, bus_rdata;
  logic [3:0]  byteen;
  logic        bus_ack;
  logic        stall, rdata_valid, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [4:0]  exc_code;
  logic [3:0]  bus_byteen;

  dm_bus_ctrl #(.TIMEOUT(TO), .TO_W(3)) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_load(mem_load),
    .load_type(load_type), .store_type(store_type), .addr(addr),
    .byteen(byteen), .wdata(wdata), .stall(stall), .rdata(rdata),
    .rdata_valid(rdata_valid), .exc_code(exc_code), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_byteen(bus_byteen),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Expected outputs for the current cycle, set by the driver
  logic        chk_en = 1'b0;
  logic        e_stall, e_req, e_rv, e_we;
  logic [4:0]  e_exc;
  logic [31:0] e_rdata, e_addr, e_wd;
  logic [3:0]  e_be;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference extension computed arithmetically from the load rules
  function automatic logic [31:0] ref_ext(input logic [2:0] lt, input logic [1:0] b, input logic [31:0] w);
    logic [31:0] hw, bt;
    hw = (w >> (b[1] ? 16 : 0)) & 32'h0000_FFFF;
    bt = (w >> (int'(b) * 8)) & 32'h0000_00FF;
    case (lt)
      3'd0:    return w;
      3'd1:    return (hw >= 32'h8000) ? hw - 32'h0001_0000 : hw;
      3'd2:    return hw;
      3'd3:    return (bt >= 32'h80) ? bt - 32'h0000_0100 : bt;
      3'd4:    return bt;
      default: return 32'h0;
    endcase
  endfunction

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("stall", {31'b0, stall}, {31'b0, e_stall});
      cmp("bus_req", {31'b0, bus_req}, {31'b0, e_req});
      cmp("rdata_valid", {31'b0, rdata_valid}, {31'b0, e_rv});
      cmp("exc_code", {27'b0, exc_code}, {27'b0, e_exc});
      cmp("rdata", rdata, e_rdata);
      if (e_req) begin
        cmp("bus_we", {31'b0, bus_we}, {31'b0, e_we});
        cmp("bus_addr", bus_addr, e_addr);
        cmp("bus_byteen", {28'b0, bus_byteen}, {28'b0, e_be});
        if (e_we) cmp("bus_wdata", bus_wdata, e_wd);
      end
    end
  end

  // One instruction in MEM; d = cycles without ack before the ack cycle
  task automatic txn(input logic v, input logic ld, input logic [2:0] lt, input logic [2:0] st,
                     input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                     input logic [31:0] rd, input int d,
                     output int sc, output logic [31:0] rdo, output logic [4:0] exo);
    logic adel, ades, go, acked;
    int k;
    adel = v && ld && ((lt == 3'd0 && a[1:0] != 2'b00) || ((lt == 3'd1 || lt == 3'd2) && a[0]));
    ades = v && !ld && ((st == 3'd0 && a[1:0] != 2'b00) || (st == 3'd1 && a[0]));
    go   = v && !adel && !ades && (ld || be != 4'b0000);
    mem_valid = v; mem_load = ld; load_type = lt; store_type = st;
    addr = a; byteen = be; wdata = wd; bus_ack = 1'b0; bus_rdata = $urandom;
    e_stall = go; e_req = 1'b0; e_rv = 1'b0;
    e_exc = adel ? 5'd4 : (ades ? 5'd5 : 5'd0);
    sc = 0;
    @(negedge clk);
    sc += int'(stall); rdo = rdata; exo = exc_code;
    @(posedge clk); #1;
    if (go) begin
      acked = 1'b0; k = 0;
      e_req = 1'b1; e_stall = 1'b1; e_exc = 5'd0; e_we = !ld;
      e_addr = {a[31:2], 2'b00}; e_be = ld ? 4'b0000 : be; e_wd = wd;
      while (!acked && k < TO) begin
        bus_ack = (k == d);
        bus_rdata = (k == d) ? rd : $urandom;
        @(negedge clk);
        sc += int'(stall);
        acked = (k == d);
        k++;
        @(posedge clk); #1;
      end
      bus_ack = 1'b0; bus_rdata = $urandom;
      e_req = 1'b0; e_stall = 1'b0; e_rv = ld; e_exc = acked ? 5'd0 : 5'd7;
      if (ld && acked) e_rdata = ref_ext(lt, a[1:0], rd);
      @(negedge clk);
      sc += int'(stall); rdo = rdata; exo = exc_code;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int sc;
    logic [31:0] rdo;
    logic [4:0]  exo;
    logic [31:0] a;
    logic [3:0]  be;
    logic [2:0]  st, lt;
    logic        ld, v;

    reset = 1'b1; mem_valid = 1'b0; mem_load = 1'b0; load_type = 3'd0;
    store_type = 3'd7; addr = 32'h0; byteen = 4'h0; wdata = 32'h0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    e_stall = 1'b0; e_req = 1'b0; e_rv = 1'b0; e_we = 1'b0; e_exc = 5'd0;
    e_rdata = 32'h0; e_addr = 32'h0; e_wd = 32'h0; e_be = 4'h0;
    #12;
    cmp("rst_bus_req", {31'b0, bus_req}, 32'd0);
    cmp("rst_bus_we", {31'b0, bus_we}, 32'd0);
    cmp("rst_bus_addr", bus_addr, 32'd0);
    cmp("rst_bus_byteen", {28'b0, bus_byteen}, 32'd0);
    cmp("rst_bus_wdata", bus_wdata, 32'd0);
    cmp("rst_rdata", rdata, 32'd0);
    cmp("rst_rdata_valid", {31'b0, rdata_valid}, 32'd0);
    cmp("rst_exc", {27'b0, exc_code}, 32'd0);
    cmp("rst_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; chk_en = 1'b1;

    // Store word, ack in the first REQ cycle
    txn(1, 0, 3'd0, 3'd0, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0, 0, sc, rdo, exo);
    cmp("t1_stall_cycles", sc, 32'd2);
    cmp("t1_exc", {27'b0, exo}, 32'd0);
    // Byte loads after three wait cycles
    txn(1, 1, 3'd3, 3'd7, 32'h203, 4'b0000, 32'h0, 32'h80FF7F01, 3, sc, rdo, exo);
    cmp("t2_lb_stall_cycles", sc, 32'd5);
    cmp("t2_lb_rdata", rdo, 32'hFFFFFF80);
    txn(1, 1, 3'd4, 3'd7, 32'h203, 4'b0000, 32'h0, 32'h80FF7F01, 3, sc, rdo, exo);
    cmp("t2_lbu_rdata", rdo, 32'h00000080);
    // Halfword loads
    txn(1, 1, 3'd1, 3'd7, 32'h202, 4'b0000, 32'h0, 32'h80011234, 0, sc, rdo, exo);
    cmp("t3_lh_rdata", rdo, 32'hFFFF8001);
    txn(1, 1, 3'd2, 3'd7, 32'h200, 4'b0000, 32'h0, 32'h80011234, 1, sc, rdo, exo);
    cmp("t3_lhu_rdata", rdo, 32'h00001234);
    // Misaligned accesses
    txn(1, 1, 3'd0, 3'd7, 32'h101, 4'b0000, 32'h0, 32'h0, 0, sc, rdo, exo);
    cmp("t4_adel_exc", {27'b0, exo}, 32'd4);
    cmp("t4_adel_stall", sc, 32'd0);
    txn(1, 0, 3'd0, 3'd1, 32'h103, 4'b1100, 32'h12345678, 32'h0, 0, sc, rdo, exo);
    cmp("t4_ades_exc", {27'b0, exo}, 32'd5);
    // Timeout: never acked
    txn(1, 1, 3'd0, 3'd7, 32'h400, 4'b0000, 32'h0, 32'h0, 100, sc, rdo, exo);
    cmp("t5_timeout_exc", {27'b0, exo}, 32'd7);
    cmp("t5_timeout_stall", sc, 32'd5);
    // Ack on the final allowed cycle
    txn(1, 1, 3'd0, 3'd7, 32'h404, 4'b0000, 32'h0, 32'hCAFEF00D, TO - 1, sc, rdo, exo);
    cmp("t6_coincide_exc", {27'b0, exo}, 32'd0);
    cmp("t6_coincide_rdata", rdo, 32'hCAFEF00D);
    // Idle instruction and store with no byte enables
    txn(0, 0, 3'd0, 3'd0, 32'h500, 4'b1111, 32'h1, 32'h0, 0, sc, rdo, exo);
    cmp("idle_stall", sc, 32'd0);
    txn(1, 0, 3'd0, 3'd7, 32'h500, 4'b0000, 32'h1, 32'h0, 0, sc, rdo, exo);
    cmp("nostore_stall", sc, 32'd0);

    // Reset during REQ
    chk_en = 1'b0;
    mem_valid = 1'b1; mem_load = 1'b1; load_type = 3'd0; store_type = 3'd7;
    addr = 32'h300; byteen = 4'b0000; bus_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cmp("pre_rst_bus_req", {31'b0, bus_req}, 32'd1);
    #2 reset = 1'b1; #1;
    cmp("mid_rst_bus_req", {31'b0, bus_req}, 32'd0);
    cmp("mid_rst_stall", {31'b0, stall}, 32'd0);
    cmp("mid_rst_rdata", rdata, 32'd0);
    e_rdata = 32'h0; mem_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    e_stall = 1'b0; e_req = 1'b0; e_rv = 1'b0; e_exc = 5'd0;
    chk_en = 1'b1;
    txn(1, 0, 3'd0, 3'd0, 32'h600, 4'b1111, 32'h0BADF00D, 32'h0, 1, sc, rdo, exo);
    cmp("post_rst_stall_cycles", sc, 32'd3);

    // Random traffic
    for (int i = 0; i < 250; i++) begin
      v  = ($urandom_range(0, 9) != 0);
      ld = $urandom_range(0, 1);
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      if (ld) begin
        lt = 3'($urandom_range(0, 5));
        if (lt == 3'd5) lt = 3'($urandom_range(5, 7));
        st = 3'd7; be = 4'b0000;
      end else begin
        lt = 3'($urandom_range(0, 4));
        case ($urandom_range(0, 4))
          0: begin st = 3'd0; be = 4'b1111; end
          1: begin st = 3'd1; be = a[1] ? 4'b1100 : 4'b0011; end
          2: begin st = 3'd2; be = 4'b0001 << a[1:0]; end
          3: begin st = 3'd3; be = 4'b1111; end
          default: begin st = 3'd7; be = 4'b0000; end
        endcase
      end
      txn(v, ld, lt, st, a, be, $urandom, $urandom, $urandom_range(0, TO + 1), sc, rdo, exo);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
